// File: rtl/task_enqueue.sv
// Producer side of the per-level TaskFIFO. A single push/pop request stream
// is checked against per-tree element counts. Legal requests are written
// into the lane FIFO picked by the tree ID; illegal ones are dropped. Each
// lane gives the distributor a registered head word and an empty flag.
module task_enqueue #(
   parameter int PTW           = 16,
   parameter int LEVEL         = 4,
   parameter int LEVEL_BITS    = $clog2(LEVEL),
   parameter int TREE_NUM      = 4,
   parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
   parameter int DEPTH         = 8,
   parameter int TREE_CAP      = 15,
   parameter int CNT_BITS      = $clog2(TREE_CAP + 1)
) (
   input  logic                         i_clk,
   input  logic                         i_arst_n,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   input  logic                         i_req_type,
   input  logic [TREE_NUM_BITS-1:0]     i_req_treeId,
   input  logic [PTW-1:0]               i_req_push_data,
   output logic                         o_drop,
   input  logic [LEVEL-1:0]             i_pop_TaskFIFO,
   output logic [PTW+TREE_NUM_BITS:0]   o_TaskFIFO_data [0:LEVEL-1],
   output logic [LEVEL-1:0]             o_TaskFIFO_empty,
   output logic [CNT_BITS-1:0]          o_tree_count [0:TREE_NUM-1]
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int WORD_W   = PTW + TREE_NUM_BITS + 1;
   localparam int ID_EXT   = (TREE_NUM_BITS > LEVEL_BITS) ? TREE_NUM_BITS : LEVEL_BITS;

   logic [WORD_W-1:0]     mem_q  [LEVEL][DEPTH];
   logic [PTR_BITS-1:0]   wptr_q [LEVEL];
   logic [PTR_BITS-1:0]   rptr_q [LEVEL];
   logic [PTR_BITS:0]     occ_q  [LEVEL];
   logic [PTR_BITS:0]     occ_d  [LEVEL];
   logic [WORD_W-1:0]     data_q [LEVEL];
   logic [CNT_BITS-1:0]   cnt_q  [TREE_NUM];
   logic [CNT_BITS-1:0]   cnt_d  [TREE_NUM];
   logic                  drop_q;
   logic                  drop_d;

   logic [ID_EXT-1:0]     tid_ext;
   logic [LEVEL_BITS-1:0] lane;
   logic [CNT_BITS-1:0]   cur_cnt;
   logic                  hs;
   logic                  legal;
   logic                  wr_en;
   logic [WORD_W-1:0]     wr_word;
   logic [LEVEL-1:0]      lane_wr;
   logic [LEVEL-1:0]      lane_pop;

   // Tree IDs narrower than the lane index are zero-extended before the
   // modulo, so every tree always lands on the same lane.
   assign tid_ext = ID_EXT'(i_req_treeId);
   assign lane    = tid_ext[LEVEL_BITS-1:0];
   assign cur_cnt = cnt_q[i_req_treeId];

   // Ready only looks at the stored occupancy: a pop in the same cycle does not free a slot.
   assign o_req_ready = (occ_q[lane] != (PTR_BITS + 1)'(DEPTH));

   assign hs      = i_req_valid & o_req_ready;
   assign legal   = i_req_type ? (cur_cnt < CNT_BITS'(TREE_CAP)) : (cur_cnt != '0);
   assign wr_en   = hs & legal;
   assign wr_word = {i_req_type, i_req_treeId, (i_req_type ? i_req_push_data : {PTW{1'b0}})};
   assign drop_d  = hs & ~legal;

   // Per-lane write/pop enables and the next occupancy of each lane.
   always_comb begin
      for (int l = 0; l < LEVEL; l++) begin
         lane_wr[l]  = wr_en && (lane == LEVEL_BITS'(l));
         lane_pop[l] = i_pop_TaskFIFO[l] && (occ_q[l] != '0);
         occ_d[l]    = occ_q[l];
         if (lane_wr[l] && !lane_pop[l]) begin
            occ_d[l] = occ_q[l] + 1'b1;
         end else if (!lane_wr[l] && lane_pop[l]) begin
            occ_d[l] = occ_q[l] - 1'b1;
         end
      end
   end

   // Next per-tree element count. Legality already prevents wrapping.
   always_comb begin
      for (int t = 0; t < TREE_NUM; t++) begin
         cnt_d[t] = cnt_q[t];
      end
      if (wr_en) begin
         cnt_d[i_req_treeId] = i_req_type ? (cur_cnt + 1'b1) : (cur_cnt - 1'b1);
      end
   end

   // Lane storage. It has no reset because the pointers and occupancy decide what is valid.
   always_ff @(posedge i_clk) begin
      for (int l = 0; l < LEVEL; l++) begin
         if (lane_wr[l]) begin
            mem_q[l][wptr_q[l]] <= wr_word;
         end
      end
   end

   // Lane pointers, occupancy and the registered head word.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         for (int l = 0; l < LEVEL; l++) begin
            wptr_q[l] <= '0;
            rptr_q[l] <= '0;
            occ_q[l]  <= '0;
            data_q[l] <= '0;
         end
      end else begin
         for (int l = 0; l < LEVEL; l++) begin
            occ_q[l] <= occ_d[l];
            if (lane_wr[l]) begin
               wptr_q[l] <= wptr_q[l] + 1'b1;
            end
            if (lane_pop[l]) begin
               rptr_q[l] <= rptr_q[l] + 1'b1;
               data_q[l] <= mem_q[l][rptr_q[l]];
            end
         end
      end
   end

   // Tree counts and the one-cycle drop pulse.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         for (int t = 0; t < TREE_NUM; t++) begin
            cnt_q[t] <= '0;
         end
         drop_q <= 1'b0;
      end else begin
         for (int t = 0; t < TREE_NUM; t++) begin
            cnt_q[t] <= cnt_d[t];
         end
         drop_q <= drop_d;
      end
   end

   // Drive the outputs straight from the state registers.
   always_comb begin
      for (int l = 0; l < LEVEL; l++) begin
         o_TaskFIFO_data[l]  = data_q[l];
         o_TaskFIFO_empty[l] = (occ_q[l] == '0);
      end
      for (int t = 0; t < TREE_NUM; t++) begin
         o_tree_count[t] = cnt_q[t];
      end
   end

   assign o_drop = drop_q;

endmodule

// File: tb/tb_task_enqueue.sv
// Directed bench for task_enqueue. It keeps a reference model of the tree
// counts and lane occupancy, plus a per-lane queue of expected task words.
module tb_task_enqueue;

   localparam int PTW   = 16;
   localparam int LEVEL = 4;
   localparam int TNB   = 2;
   localparam int DEPTH = 8;
   localparam int CAP   = 15;
   localparam int CNTB  = 4;
   localparam int W     = PTW + TNB + 1;

   logic            clk = 1'b0;
   logic            arst_n;
   logic            req_valid;
   logic            req_ready;
   logic            req_type;
   logic [TNB-1:0]  req_tid;
   logic [PTW-1:0]  req_data;
   logic            drop;
   logic [LEVEL-1:0] pop;
   logic [W-1:0]    fifo_data [0:LEVEL-1];
   logic [LEVEL-1:0] fifo_empty;
   logic [CNTB-1:0] tree_count [0:3];

   always #5 clk = ~clk;

   task_enqueue #(
      .PTW(PTW), .LEVEL(LEVEL), .TREE_NUM(4), .DEPTH(DEPTH), .TREE_CAP(CAP)
   ) dut (
      .i_clk            (clk),
      .i_arst_n         (arst_n),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_type       (req_type),
      .i_req_treeId     (req_tid),
      .i_req_push_data  (req_data),
      .o_drop           (drop),
      .i_pop_TaskFIFO   (pop),
      .o_TaskFIFO_data  (fifo_data),
      .o_TaskFIFO_empty (fifo_empty),
      .o_tree_count     (tree_count)
   );

   int errors = 0;
   int checks = 0;

   logic [W-1:0] sb0[$];
   logic [W-1:0] sb1[$];
   logic [W-1:0] sb2[$];
   logic [W-1:0] sb3[$];
   int           m_cnt [4];
   int           m_occ [4];
   logic [W-1:0] m_data [4];
   logic         m_drop;

   function automatic void sb_push(input int l, input logic [W-1:0] w);
      case (l)
         0: sb0.push_back(w);
         1: sb1.push_back(w);
         2: sb2.push_back(w);
         default: sb3.push_back(w);
      endcase
   endfunction

   function automatic logic [W-1:0] sb_pop(input int l);
      case (l)
         0: return sb0.pop_front();
         1: return sb1.pop_front();
         2: return sb2.pop_front();
         default: return sb3.pop_front();
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i]  = 0;
         m_occ[i]  = 0;
         m_data[i] = '0;
      end
      m_drop = 1'b0;
      sb0.delete(); sb1.delete(); sb2.delete(); sb3.delete();
   endtask

   task automatic check_outputs(input string ctx);
      for (int l = 0; l < LEVEL; l++) begin
         chk($sformatf("%s empty%0d", ctx, l), fifo_empty[l], (m_occ[l] == 0));
         chk($sformatf("%s data%0d", ctx, l), fifo_data[l], m_data[l]);
      end
      for (int t = 0; t < 4; t++) begin
         chk($sformatf("%s count%0d", ctx, t), tree_count[t], m_cnt[t]);
      end
      chk({ctx, " drop"}, drop, m_drop);
   endtask

   // One clock of stimulus. Inputs are driven on the falling edge, ready is
   // checked, the model is advanced, and outputs are checked 1 time unit
   // after the rising edge.
   task automatic step(input bit v, input bit typ, input int tid,
                       input logic [15:0] d, input logic [3:0] pops, input string ctx);
      int  lane;
      bit  rdy;
      bit  ok;
      @(negedge clk);
      req_valid = v;
      req_type  = typ;
      req_tid   = tid[1:0];
      req_data  = d;
      pop       = pops;
      #1;
      lane = tid % LEVEL;
      rdy  = (m_occ[lane] != DEPTH);
      chk({ctx, " ready"}, req_ready, rdy);
      for (int l = 0; l < LEVEL; l++) begin
         if (pops[l] && m_occ[l] > 0) begin
            m_data[l] = sb_pop(l);
            m_occ[l]--;
         end
      end
      m_drop = 1'b0;
      if (v && rdy) begin
         ok = typ ? (m_cnt[tid] < CAP) : (m_cnt[tid] > 0);
         if (ok) begin
            sb_push(lane, {typ, tid[1:0], (typ ? d : 16'h0000)});
            m_occ[lane]++;
            m_cnt[tid] += typ ? 1 : -1;
         end else begin
            m_drop = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check_outputs(ctx);
   endtask

   task automatic apply_reset(input string ctx);
      @(negedge clk);
      req_valid = 1'b0;
      pop       = '0;
      arst_n    = 1'b0;
      #1;
      model_clear();
      for (int l = 0; l < LEVEL; l++) begin
         chk($sformatf("%s rst empty%0d", ctx, l), fifo_empty[l], 1'b1);
         chk($sformatf("%s rst data%0d", ctx, l), fifo_data[l], 0);
      end
      for (int t = 0; t < 4; t++) begin
         chk($sformatf("%s rst count%0d", ctx, t), tree_count[t], 0);
      end
      chk({ctx, " rst drop"}, drop, 1'b0);
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   initial begin
      arst_n    = 1'b1;
      req_valid = 1'b0;
      req_type  = 1'b0;
      req_tid   = '0;
      req_data  = '0;
      pop       = '0;
      model_clear();

      apply_reset("init");
      step(0, 0, 0, 16'h0, 4'b0000, "idle");
      step(0, 0, 0, 16'h0, 4'b1111, "pop_all_empty");

      step(1, 1, 2, 16'h00AB, 4'b0000, "push_t2");
      step(0, 0, 0, 16'h0, 4'b0100, "pop_l2");
      chk("t2 head word", fifo_data[2], {1'b1, 2'd2, 16'h00AB});
      chk("t2 empty after pop", fifo_empty[2], 1'b1);

      step(1, 0, 1, 16'h1234, 4'b0000, "bad_pop_t1");
      chk("bad pop drop", drop, 1'b1);
      step(0, 0, 0, 16'h0, 4'b0000, "after_drop");

      for (int i = 0; i < 8; i++) begin
         step(1, 1, 3, 16'h0300 + 16'(i), 4'b0000, $sformatf("push_t3_%0d", i));
      end
      step(1, 1, 3, 16'h0308, 4'b0000, "t3_full");
      chk("lane3 full ready", req_ready, 1'b0);
      step(1, 1, 0, 16'h0001, 4'b0000, "t0_while_l3_full");
      step(1, 1, 3, 16'h0308, 4'b1000, "t3_pop_no_bypass");
      step(1, 1, 3, 16'h0308, 4'b0000, "t3_ninth");
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 0, 16'h0, 4'b1001, $sformatf("drain3_%0d", i));
      end

      step(1, 1, 1, 16'h0111, 4'b0000, "pre_rst_a");
      step(1, 1, 2, 16'h0222, 4'b0000, "pre_rst_b");
      apply_reset("mid");
      step(0, 0, 0, 16'h0, 4'b0000, "post_rst");

      for (int i = 0; i < 16; i++) begin
         step(1, 1, 0, 16'(i + 1), 4'b0001, $sformatf("push_t0_%0d", i));
         if (i == 15) chk("16th push drop", drop, 1'b1);
      end
      chk("t0 count cap", tree_count[0], 15);
      step(0, 0, 0, 16'h0, 4'b0001, "drain0_a");
      step(0, 0, 0, 16'h0, 4'b0001, "drain0_b");

      for (int i = 0; i < 4; i++) begin
         step(1, 1, 1, 16'h0A00 + 16'(i), 4'b0000, $sformatf("fill1_%0d", i));
      end
      step(1, 1, 1, 16'h0A04, 4'b0010, "wr_pop_l1");
      for (int i = 5; i < 9; i++) begin
         step(1, 1, 1, 16'h0A00 + 16'(i), 4'b0000, $sformatf("fill1_%0d", i));
      end
      step(1, 1, 1, 16'h0AFF, 4'b0000, "l1_full");
      chk("t1 count", tree_count[1], 9);
      step(0, 0, 0, 16'h0, 4'b0010, "drain1_0");
      step(1, 0, 1, 16'h5555, 4'b0000, "pop_req_t1");
      for (int i = 1; i < 10; i++) begin
         step(0, 0, 0, 16'h0, 4'b0010, $sformatf("drain1_%0d", i));
      end
      chk("pop word on lane1", fifo_data[1], {1'b0, 2'd1, 16'h0000});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/task_enqueue.md
Name: task_enqueue

Overview:
- Producer end of the per-level TaskFIFO interface.
- Accepts a single stream of push/pop requests tagged with a tree ID and checks each one against a per-tree occupancy count, dropping illegal requests.
- Writes legal requests into one of LEVEL internal task FIFOs, selected by tree ID.
- Presents each FIFO to the task distributor through a pop/data/empty interface with 1-cycle read latency. This interface uses the task word format {type(1=push,0=pop), TreeId, PushData}.

Parameters:
- PTW, 16, payload width.
- LEVEL, 4, number of lanes (RPUs, one FIFO per lane); must be a power of 2.
- LEVEL_BITS, $clog2(LEVEL), lane index width.
- TREE_NUM, 4, number of logical trees.
- TREE_NUM_BITS, $clog2(TREE_NUM), tree ID width.
- DEPTH, 8, entries per lane FIFO; must be a power of 2.
- TREE_CAP, 15, maximum elements per tree.
- CNT_BITS, $clog2(TREE_CAP+1), tree count width.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request ready; the handshake occurs when valid&&ready.
- i_req_type  in  1  1=push, 0=pop.
- i_req_treeId  in  TREE_NUM_BITS  target tree.
- i_req_push_data  in  PTW  push payload; ignored for pop.
- o_drop  out  1  pulses 1 cycle after a handshake whose request was discarded.
- i_pop_TaskFIFO  in  LEVEL  per-lane pop strobe from the distributor.
- o_TaskFIFO_data  out  [PTW+TREE_NUM_BITS:0] x [0:LEVEL-1]  per-lane head task word.
- o_TaskFIFO_empty  out  LEVEL  per-lane empty flag.
- o_tree_count  out  CNT_BITS x [0:TREE_NUM-1]  logical element count per tree.

Behaviour:
- Reset (async, active-low):
  - all FIFO pointers and occupancy counts = 0;
  - o_TaskFIFO_empty = all 1s;
  - o_TaskFIFO_data = 0 for every lane;
  - o_tree_count = 0 for every tree;
  - o_drop = 0.
  - Reset mid-operation discards all queued tasks; no partial writes survive.
- Lane select: lane = i_req_treeId mod LEVEL, i.e. the low LEVEL_BITS bits of the tree ID, zero-extended when TREE_NUM_BITS < LEVEL_BITS. Per-tree ordering is therefore preserved, because each tree always maps to the same lane.
- Ready:
  - o_req_ready = (occupancy[lane] != DEPTH), evaluated combinationally from the current i_req_treeId.
  - A same-cycle pop on that lane does not raise ready (no bypass).
  - Ready is independent of i_req_valid.
- Legality at handshake:
  - A push is legal iff tree_count[treeId] < TREE_CAP.
  - A pop is legal iff tree_count[treeId] > 0.
- Legal request:
  - write {i_req_type, i_req_treeId, data} into the lane FIFO, with data = i_req_push_data for push and 0 for pop;
  - the tree count increments (push) or decrements (pop) at the same clock edge.
- Illegal request:
  - the handshake still completes;
  - nothing is written and the count is unchanged;
  - o_drop = 1 in the next cycle only.
- Back-to-back requests to the same tree see the count updated by the previous cycle's handshake. The count never wraps.
- FIFO read:
  - i_pop_TaskFIFO[l] in cycle t with empty[l]=0 advances the read pointer.
  - The popped word appears on o_TaskFIFO_data[l] in cycle t+1 (registered) and holds until the next effective pop.
  - A pop while empty is ignored: pointer, data and occupancy are all unchanged.
- Empty:
  - o_TaskFIFO_empty[l] = (occupancy[l]==0), registered state.
  - A write in cycle t clears empty from cycle t+1.
  - An effective pop of the last entry sets empty from the next cycle.
- Simultaneous write and pop on the same lane: both take effect and occupancy is unchanged. When occupancy==DEPTH, ready is low, so only the pop occurs.
- Pointers are LEVEL-independent log2(DEPTH)-bit counters that wrap modulo DEPTH. Occupancy is a (log2(DEPTH)+1)-bit counter.
- Lanes are fully independent: pops and writes on different lanes in the same cycle do not interact.

Test Plan:
- Reset, then idle:
  - o_TaskFIFO_empty=4'b1111, all o_tree_count=0, o_req_ready=1, o_drop=0.
- Push tree 2 data 0x00AB:
  - cycle+1: empty[2]=0, o_tree_count[2]=1.
  - Pop lane 2 at cycle c: at c+1, o_TaskFIFO_data[2]={1'b1,2'd2,16'h00AB}; empty[2]=1 from c+1.
- Pop request for tree 1 with count 0:
  - handshake completes; o_drop=1 for exactly one cycle; empty[1] stays 1; count stays 0.
- Nine pushes to tree 3 with no lane pops:
  - after 8 accepted pushes, o_req_ready=0 while treeId=3;
  - a request to tree 0 is still accepted that cycle;
  - popping lane 3 once lets the 9th push complete the following cycle.
- 16 pushes to tree 0, draining lane 0 continuously:
  - first 15 enqueue; the 16th gives o_drop=1;
  - o_tree_count[0]=15;
  - output order is payloads 1..15 across the pointer wrap.
- Same-cycle write and pop on lane 1 at occupancy 4:
  - occupancy stays 4, FIFO order is preserved.
  - Asserting i_arst_n=0 mid-stream sets all lanes empty and counts to 0 immediately.
